// File: rtl/predec_enc_pkg.sv
// Shared types and constants for the 4->2 active-low predecode encoder.
package predec_enc_pkg;

    localparam int GRP_LINES  = 4;
    localparam int GRP_CODE_W = 2;

    typedef logic [GRP_LINES-1:0]  grp_lines_t;
    typedef logic [GRP_CODE_W-1:0] grp_code_t;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        ERR_HOLD = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/predecode_encoder_4_2_if.sv
// Input/output handshake bundle of predecode_encoder_4_2.
// Optional addr_par member appears when PREDEC_ENC_PARITY_EN is defined.
interface predecode_encoder_4_2_if
    import predec_enc_pkg::*;
#(
    parameter int NUM_GROUPS = 2
);
    logic [GRP_LINES*NUM_GROUPS-1:0]  pre_in;
    logic                             in_valid;
    logic                             in_ready;
    logic [GRP_CODE_W*NUM_GROUPS-1:0] addr_out;
    logic                             addr_err;
    logic                             out_valid;
    logic                             out_ready;
`ifdef PREDEC_ENC_PARITY_EN
    logic                             addr_par;

    modport master (
        output pre_in, in_valid, out_ready,
        input  in_ready, addr_out, addr_err, out_valid, addr_par
    );
    modport slave (
        input  pre_in, in_valid, out_ready,
        output in_ready, addr_out, addr_err, out_valid, addr_par
    );
`else
    modport master (
        output pre_in, in_valid, out_ready,
        input  in_ready, addr_out, addr_err, out_valid
    );
    modport slave (
        input  pre_in, in_valid, out_ready,
        output in_ready, addr_out, addr_err, out_valid
    );
`endif
endinterface

// File: rtl/predec_enc_group.sv
// One active-low 4-line group back to its 2-bit code; bad=1 unless exactly one line is low.
module predec_enc_group
    import predec_enc_pkg::*;
(
    input  grp_lines_t lines,
    output grp_code_t  code,
    output logic       bad
);

    always_comb begin
        code = 2'b00;
        bad  = 1'b0;
        unique case (lines)
            4'b1110: code = 2'd0;
            4'b1101: code = 2'd1;
            4'b1011: code = 2'd2;
            4'b0111: code = 2'd3;
            default: bad  = 1'b1;
        endcase
    end

endmodule

// File: rtl/predecode_encoder_4_2.sv
// Predecode encoder: per-group 4->2 encode, 2-entry valid/ready buffer, RUN/ERR_HOLD FSM
// and saturating malformed-code counter. Define PREDEC_ENC_PARITY_EN to add addr_par.
module predecode_encoder_4_2
    import predec_enc_pkg::*;
#(
    parameter int NUM_GROUPS  = 2,
    parameter int ERR_CNT_W   = 8,
    parameter bit STOP_ON_ERR = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    predecode_encoder_4_2_if.slave bus,
    input  logic                   err_clear,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic                   halted
);

    localparam int ADDR_W = GRP_CODE_W * NUM_GROUPS;
    localparam int DEPTH  = 2;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    logic [ADDR_W-1:0]     enc_addr;
    logic [NUM_GROUPS-1:0] grp_bad;
    logic                  enc_err;

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
        predec_enc_group u_grp (
            .lines (bus.pre_in[g*GRP_LINES +: GRP_LINES]),
            .code  (enc_addr[g*GRP_CODE_W +: GRP_CODE_W]),
            .bad   (grp_bad[g])
        );
    end

    assign enc_err = |grp_bad;

    logic [ADDR_W-1:0]    addr_q [DEPTH];
    logic [ADDR_W-1:0]    addr_d [DEPTH];
    logic [DEPTH-1:0]     err_q, err_d;
`ifdef PREDEC_ENC_PARITY_EN
    logic [DEPTH-1:0]     par_q, par_d;
`endif
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic [1:0]           count_q, count_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    // live_q holds in_ready low until the first edge after reset release.
    logic                 live_q;
    fsm_state_t           state_q;
    logic                 halted_q;

    logic in_ready, out_valid, push, pop, bad_push;

    assign in_ready  = live_q && (count_q < 2'd2) && (state_q == RUN);
    assign out_valid = (count_q != 2'd0);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;
    assign bad_push  = push && enc_err;

    always_comb begin
        addr_d   = addr_q;
        err_d    = err_q;
`ifdef PREDEC_ENC_PARITY_EN
        par_d    = par_q;
`endif
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            addr_d[wr_ptr_q] = enc_addr;
            err_d[wr_ptr_q]  = enc_err;
`ifdef PREDEC_ENC_PARITY_EN
            par_d[wr_ptr_q]  = ^enc_addr;
`endif
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // A bad word accepted alongside err_clear still counts as the first new event.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clear) begin
            err_cnt_d = bad_push ? ERR_CNT_W'(1) : '0;
        end else if (bad_push && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
            err_q     <= '0;
`ifdef PREDEC_ENC_PARITY_EN
            par_q     <= '0;
`endif
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            err_cnt_q <= '0;
            live_q    <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            err_q     <= err_d;
`ifdef PREDEC_ENC_PARITY_EN
            par_q     <= par_d;
`endif
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
            live_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (STOP_ON_ERR && bad_push) begin
                        state_q  <= ERR_HOLD;
                        halted_q <= 1'b1;
                    end
                end
                ERR_HOLD: begin
                    if (err_clear) begin
                        state_q  <= RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.addr_out  = addr_q[rd_ptr_q];
    assign bus.addr_err  = err_q[rd_ptr_q];
`ifdef PREDEC_ENC_PARITY_EN
    assign bus.addr_par  = par_q[rd_ptr_q];
`endif
    assign err_cnt = err_cnt_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_predecode_encoder_4_2.sv
// Directed bench: default instance (STOP_ON_ERR=1) and a small-counter instance (ERR_CNT_W=2, STOP_ON_ERR=0).
module tb_predecode_encoder_4_2;

    logic clk;
    logic rst;
    logic err_clear_a, err_clear_b;
    logic [7:0] err_cnt_a;
    logic [1:0] err_cnt_b;
    logic halted_a, halted_b;

    int total = 0;
    int bad   = 0;

    predecode_encoder_4_2_if #(.NUM_GROUPS(2)) bus_a ();
    predecode_encoder_4_2_if #(.NUM_GROUPS(2)) bus_b ();

    predecode_encoder_4_2 #(.NUM_GROUPS(2), .ERR_CNT_W(8), .STOP_ON_ERR(1'b1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_a),
        .err_clear (err_clear_a),
        .err_cnt   (err_cnt_a),
        .halted    (halted_a)
    );

    predecode_encoder_4_2 #(.NUM_GROUPS(2), .ERR_CNT_W(2), .STOP_ON_ERR(1'b0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_b),
        .err_clear (err_clear_b),
        .err_cnt   (err_cnt_b),
        .halted    (halted_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        err_clear_a = 1'b0;
        err_clear_b = 1'b0;
        bus_a.pre_in = 8'hFF; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
        bus_b.pre_in = 8'hFF; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst_addr_out",  32'(bus_a.addr_out),  32'd0);
        chk("rst_addr_err",  32'(bus_a.addr_err),  32'd0);
        chk("rst_err_cnt",   32'(err_cnt_a),       32'd0);
        chk("rst_halted",    32'(halted_a),        32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(bus_a.in_ready), 32'd1);

        // Single good word, buffer empty: visible the next cycle.
        bus_a.pre_in = 8'b1110_1101; bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b1;
        step();
        bus_a.in_valid = 1'b0;
        chk("t1_out_valid", 32'(bus_a.out_valid), 32'd1);
        chk("t1_addr_out",  32'(bus_a.addr_out),  32'h1);
        chk("t1_addr_err",  32'(bus_a.addr_err),  32'd0);
        step();
        chk("t1_drained", 32'(bus_a.out_valid), 32'd0);

        // Fill to two entries with the sink stalled, then drain in order.
        bus_a.out_ready = 1'b0;
        bus_a.pre_in = 8'b1110_0111; bus_a.in_valid = 1'b1;
        step();
        chk("t2_ready_after1", 32'(bus_a.in_ready), 32'd1);
        bus_a.pre_in = 8'b0111_1110;
        step();
        chk("t2_ready_full", 32'(bus_a.in_ready), 32'd0);
        chk("t2_head0",      32'(bus_a.addr_out), 32'h3);
        bus_a.pre_in = 8'b1011_1101;
        step();
        chk("t2_head_stable", 32'(bus_a.addr_out), 32'h3);
        chk("t2_still_full",  32'(bus_a.in_ready), 32'd0);
        bus_a.out_ready = 1'b1;
        step();
        chk("t2_head1",  32'(bus_a.addr_out), 32'hC);
        chk("t2_ready1", 32'(bus_a.in_ready), 32'd1);
        step();
        bus_a.in_valid = 1'b0;
        chk("t2_head2",  32'(bus_a.addr_out),  32'h9);
        chk("t2_valid2", 32'(bus_a.out_valid), 32'd1);
        step();
        chk("t2_empty", 32'(bus_a.out_valid), 32'd0);

        // Malformed group 1 halts the default instance.
        bus_a.out_ready = 1'b0;
        bus_a.pre_in = 8'b1100_1110; bus_a.in_valid = 1'b1;
        step();
        bus_a.in_valid = 1'b0;
        chk("t3_addr_out", 32'(bus_a.addr_out), 32'h0);
        chk("t3_addr_err", 32'(bus_a.addr_err), 32'd1);
        chk("t3_err_cnt",  32'(err_cnt_a),      32'd1);
        chk("t3_halted",   32'(halted_a),       32'd1);
        chk("t3_in_ready", 32'(bus_a.in_ready), 32'd0);
        bus_a.out_ready = 1'b1;
        step();
        chk("t3_drained",     32'(bus_a.out_valid), 32'd0);
        chk("t3_still_halt",  32'(halted_a),        32'd1);
        err_clear_a = 1'b1;
        step();
        err_clear_a = 1'b0;
        chk("t3_clr_halted", 32'(halted_a),        32'd0);
        chk("t3_clr_cnt",    32'(err_cnt_a),       32'd0);
        chk("t3_clr_ready",  32'(bus_a.in_ready),  32'd1);

        // Saturation on the 2-bit counter, no halting.
        bus_b.pre_in = 8'hFF; bus_b.in_valid = 1'b1; bus_b.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_err_cnt", 32'(err_cnt_b), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        chk("t4_addr_err", 32'(bus_b.addr_err), 32'd1);
        chk("t4_no_halt",  32'(halted_b),       32'd0);
        chk("t4_ready",    32'(bus_b.in_ready), 32'd1);
        err_clear_b = 1'b1;
        step();
        err_clear_b = 1'b0;
        bus_b.in_valid = 1'b0;
        chk("t4_clr_and_bad", 32'(err_cnt_b), 32'd1);

        // Parity word at head, then a bad word queued behind it.
        bus_a.out_ready = 1'b0;
        bus_a.pre_in = 8'b0111_1011; bus_a.in_valid = 1'b1;
        step();
        chk("t6_addr_out", 32'(bus_a.addr_out), 32'hE);
        chk("t6_addr_err", 32'(bus_a.addr_err), 32'd0);
`ifdef PREDEC_ENC_PARITY_EN
        chk("t6_addr_par", 32'(bus_a.addr_par), 32'd1);
`endif
        bus_a.pre_in = 8'b1100_1110;
        step();
        bus_a.in_valid = 1'b0;
        chk("t5_pre_cnt",  32'(err_cnt_a),      32'd1);
        chk("t5_pre_head", 32'(bus_a.addr_out), 32'hE);

        // Asynchronous reset mid-cycle with two entries buffered.
        #3;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid",  32'(bus_a.out_valid), 32'd0);
        chk("t5_rst_addr",   32'(bus_a.addr_out),  32'd0);
        chk("t5_rst_cnt",    32'(err_cnt_a),       32'd0);
        chk("t5_rst_halted", 32'(halted_a),        32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("t5_after_valid", 32'(bus_a.out_valid), 32'd0);
        chk("t5_after_ready", 32'(bus_a.in_ready),  32'd1);
        chk("t5_after_cnt",   32'(err_cnt_a),       32'd0);

        // err_clear with a simultaneous bad word: counted, and the halt wins.
        bus_a.pre_in = 8'hFF; bus_a.in_valid = 1'b1; err_clear_a = 1'b1;
        step();
        bus_a.in_valid = 1'b0; err_clear_a = 1'b0;
        chk("t7_cnt",    32'(err_cnt_a),      32'd1);
        chk("t7_halted", 32'(halted_a),       32'd1);
        chk("t7_err",    32'(bus_a.addr_err), 32'd1);
        bus_a.out_ready = 1'b1; err_clear_a = 1'b1;
        step();
        err_clear_a = 1'b0;
        chk("t7_released", 32'(halted_a),        32'd0);
        chk("t7_empty",    32'(bus_a.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
